// File: rtl/openhw_ahb_pkg.sv
// Shared AHB-Lite encodings and bus-controller state for the cache/LSU bus master.
package openhw_ahb_pkg;

   typedef enum logic [1:0] {
      HT_IDLE   = 2'b00,
      HT_BUSY   = 2'b01,
      HT_NONSEQ = 2'b10,
      HT_SEQ    = 2'b11
   } htrans_t;

   localparam logic [2:0] HB_SINGLE = 3'b000;
   localparam logic [2:0] HB_INCR   = 3'b001;
   localparam logic [2:0] HB_WRAP4  = 3'b010;
   localparam logic [2:0] HB_INCR4  = 3'b011;
   localparam logic [2:0] HB_WRAP8  = 3'b100;
   localparam logic [2:0] HB_INCR8  = 3'b101;
   localparam logic [2:0] HB_WRAP16 = 3'b110;
   localparam logic [2:0] HB_INCR16 = 3'b111;

   typedef enum logic [2:0] {
      ADR_PHASE,
      DATA_PHASE,
      MEM3,
      CACHE_FETCH,
      CACHE_WRITEBACK,
      ERR
   } busstate_t;

   // Two-beat lines have no WRAP2 encoding, so they fall back to undefined-length INCR.
   function automatic logic [2:0] burst_type(input int beats, input bit wrap_en);
      case (beats)
         2:       return HB_INCR;
         4:       return wrap_en ? HB_WRAP4  : HB_INCR4;
         8:       return wrap_en ? HB_WRAP8  : HB_INCR8;
         16:      return wrap_en ? HB_WRAP16 : HB_INCR16;
         default: return HB_SINGLE;
      endcase
   endfunction

endpackage

// File: rtl/openhw_beatcounter.sv
// Beat counter for cache bursts: address-phase and data-phase counts plus the
// latched start beat, combined into wrapped beat indices.
module openhw_beatcounter #(
   parameter int BEATS = 4,
   parameter int LOGB  = 2
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            load,
   input  logic            adv,
   input  logic            clr,
   input  logic [LOGB-1:0] start_in,
   output logic [LOGB-1:0] beat_index,
   output logic [LOGB-1:0] beat_index_dly,
   output logic            last
);

   localparam logic [LOGB-1:0] MASK = LOGB'(BEATS - 1);

   logic [LOGB-1:0] start_q;
   logic [LOGB-1:0] cnt;
   logic [LOGB-1:0] dcnt;
   logic [LOGB-1:0] start_now;

   // Loading means beat 0 of a new burst is accepted this cycle, so the
   // address count moves straight to 1 while the data count restarts at 0.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         start_q <= '0;
         cnt     <= '0;
         dcnt    <= '0;
      end else if (load) begin
         start_q <= start_in;
         cnt     <= LOGB'(1) & MASK;
         dcnt    <= '0;
      end else if (clr) begin
         start_q <= '0;
         cnt     <= '0;
         dcnt    <= '0;
      end else if (adv) begin
         cnt     <= (cnt + LOGB'(1)) & MASK;
         dcnt    <= cnt;
      end
   end

   assign start_now      = load ? start_in : start_q;
   assign beat_index     = (start_now + cnt) & MASK;
   assign beat_index_dly = (start_q + dcnt) & MASK;
   assign last           = (dcnt == MASK);

endmodule

// File: rtl/openhw_busburstfsm.sv
// AHB-Lite master controller: uncached single transfers and cache-line bursts
// (critical-word-first WRAP or INCR), back-to-back pipelining and error termination.
module openhw_busburstfsm
   import openhw_ahb_pkg::*;
#(
   parameter int BEATS           = 4,
   parameter int LOGB            = (BEATS > 1) ? $clog2(BEATS) : 1,
   parameter bit WRAP_EN         = 1'b1,
   parameter bit BURST_EN        = 1'b1,
   parameter bit READ_ONLY_CACHE = 1'b0
) (
   input  logic            HCLK,
   input  logic            HRESET,
   input  logic            Stall,
   input  logic            Flush,
   input  logic [1:0]      BusRW,
   input  logic [1:0]      CacheBusRW,
   input  logic [LOGB-1:0] CritBeat,
   input  logic            HREADY,
   input  logic            HRESP,
   output logic [1:0]      HTRANS,
   output logic            HWRITE,
   output logic [2:0]      HBURST,
   output logic [LOGB-1:0] BeatIndex,
   output logic [LOGB-1:0] BeatIndexDelayed,
   output logic            SelBusBeat,
   output logic            CaptureEn,
   output logic            CacheBusAck,
   output logic            BusErr,
   output logic            BusStall,
   output logic            BusCommitted
);

   localparam logic [2:0] HB      = BURST_EN ? burst_type(BEATS, WRAP_EN) : HB_SINGLE;
   localparam htrans_t    BURST_T = BURST_EN ? HT_SEQ : HT_NONSEQ;

   busstate_t       state, next;
   htrans_t         ht;
   logic            err_q;
   logic            err_cache;
   logic            load, adv, clr, last;
   logic            go, pend, in_burst;
   logic [LOGB-1:0] start_in;

   assign start_in = WRAP_EN ? CritBeat : '0;
   // Reset is folded into the start condition so nothing is issued while it is held.
   assign go       = HREADY & ~Flush & ~HRESET;
   assign pend     = |CacheBusRW;
   assign in_burst = (state == CACHE_FETCH) | (state == CACHE_WRITEBACK);

   openhw_beatcounter #(.BEATS(BEATS), .LOGB(LOGB)) u_cnt (
      .clk            (HCLK),
      .rst            (HRESET),
      .load           (load),
      .adv            (adv),
      .clr            (clr),
      .start_in       (start_in),
      .beat_index     (BeatIndex),
      .beat_index_dly (BeatIndexDelayed),
      .last           (last)
   );

   always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET) begin
         state     <= ADR_PHASE;
         err_q     <= 1'b0;
         err_cache <= 1'b0;
      end else begin
         state <= next;
         err_q <= ((state == ERR) & (next == MEM3)) | ((state == MEM3) & (next == MEM3) & err_q);
         if ((next == ERR) && (state != ERR)) err_cache <= in_burst;
      end
   end

   always_comb begin
      next        = state;
      ht          = HT_IDLE;
      HWRITE      = 1'b0;
      HBURST      = HB_SINGLE;
      CaptureEn   = 1'b0;
      CacheBusAck = 1'b0;
      BusErr      = 1'b0;
      BusStall    = 1'b0;
      SelBusBeat  = 1'b0;
      load        = 1'b0;
      adv         = 1'b0;
      clr         = 1'b0;
      case (state)
         ADR_PHASE: begin
            SelBusBeat = (BusRW[0] | CacheBusRW[0]) & ~HRESET;
            BusStall   = ((|BusRW) | pend) & ~Flush & ~HRESET;
            if (go & (|BusRW)) begin
               next   = DATA_PHASE;
               ht     = HT_NONSEQ;
               HWRITE = BusRW[0];
            end else if (go & pend) begin
               next   = CacheBusRW[0] ? CACHE_WRITEBACK : CACHE_FETCH;
               ht     = HT_NONSEQ;
               HWRITE = CacheBusRW[0];
               HBURST = HB;
               load   = 1'b1;
            end
         end
         DATA_PHASE: begin
            BusStall   = 1'b1;
            SelBusBeat = BusRW[0];
            CaptureEn  = BusRW[1] & HREADY;
            if (HREADY & ~HRESP)      next = MEM3;
            else if (HRESP & ~HREADY) next = ERR;
         end
         MEM3: begin
            BusErr = err_q;
            if (Flush | ~Stall) next = ADR_PHASE;
         end
         CACHE_FETCH, CACHE_WRITEBACK: begin
            SelBusBeat = 1'b1;
            BusStall   = ~(HREADY & last);
            CaptureEn  = (state == CACHE_FETCH) & HREADY & ~HRESP;
            if (~last) begin
               ht     = BURST_T;
               HWRITE = (state == CACHE_WRITEBACK);
               HBURST = HB;
            end
            if (HRESP & ~HREADY) begin
               next = ERR;
            end else if (HREADY & ~last) begin
               adv = 1'b1;
            end else if (HREADY) begin
               CacheBusAck = 1'b1;
               // Next line request overlaps the final data beat: no IDLE gap.
               if (pend) begin
                  ht     = HT_NONSEQ;
                  HWRITE = CacheBusRW[0];
                  HBURST = HB;
                  load   = 1'b1;
                  next   = CacheBusRW[0] ? CACHE_WRITEBACK : CACHE_FETCH;
               end else begin
                  clr  = 1'b1;
                  next = ADR_PHASE;
               end
            end
         end
         ERR: begin
            SelBusBeat = 1'b1;
            BusStall   = 1'b1;
            if (HREADY) begin
               BusErr = 1'b1;
               clr    = 1'b1;
               if (err_cache) begin
                  CacheBusAck = 1'b1;
                  next        = ADR_PHASE;
               end else begin
                  next = MEM3;
               end
            end
         end
         default: next = ADR_PHASE;
      endcase
   end

   assign HTRANS       = ht;
   assign BusCommitted = (state != ADR_PHASE) & ~(READ_ONLY_CACHE & (state == MEM3));

endmodule

// File: tb/tb_openhw_busburstfsm.sv
// Directed bench for the AHB burst controller with default parameters (4 beats, WRAP).
module tb_openhw_busburstfsm;

   logic       HCLK, HRESET, Stall, Flush, HREADY, HRESP;
   logic [1:0] BusRW, CacheBusRW, CritBeat;
   logic [1:0] HTRANS;
   logic       HWRITE;
   logic [2:0] HBURST;
   logic [1:0] BeatIndex, BeatIndexDelayed;
   logic       SelBusBeat, CaptureEn, CacheBusAck, BusErr, BusStall, BusCommitted;

   int n_chk = 0;
   int n_err = 0;

   openhw_busburstfsm dut (
      .HCLK(HCLK), .HRESET(HRESET), .Stall(Stall), .Flush(Flush),
      .BusRW(BusRW), .CacheBusRW(CacheBusRW), .CritBeat(CritBeat),
      .HREADY(HREADY), .HRESP(HRESP), .HTRANS(HTRANS), .HWRITE(HWRITE),
      .HBURST(HBURST), .BeatIndex(BeatIndex), .BeatIndexDelayed(BeatIndexDelayed),
      .SelBusBeat(SelBusBeat), .CaptureEn(CaptureEn), .CacheBusAck(CacheBusAck),
      .BusErr(BusErr), .BusStall(BusStall), .BusCommitted(BusCommitted)
   );

   initial HCLK = 1'b0;
   always #5 HCLK = ~HCLK;

   task automatic chk(input string tag, input int obs, input int exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge HCLK);
      #1;
   endtask

   initial begin
      HRESET = 1'b1; Stall = 1'b0; Flush = 1'b0; HREADY = 1'b1; HRESP = 1'b0;
      BusRW = 2'b00; CacheBusRW = 2'b00; CritBeat = 2'd0;
      tick(); tick();
      chk("rst_htrans", int'(HTRANS), 0);
      chk("rst_hwrite", int'(HWRITE), 0);
      chk("rst_hburst", int'(HBURST), 0);
      chk("rst_bidx", int'(BeatIndex), 0);
      chk("rst_ack", int'(CacheBusAck), 0);
      chk("rst_stall", int'(BusStall), 0);
      chk("rst_commit", int'(BusCommitted), 0);
      HRESET = 1'b0;
      tick();

      // fetch, critical beat 2, no wait states
      CacheBusRW = 2'b10; CritBeat = 2'd2; #3;
      chk("f1_c0_htrans", int'(HTRANS), 2);
      chk("f1_c0_bidx", int'(BeatIndex), 2);
      chk("f1_c0_hburst", int'(HBURST), 2);
      chk("f1_c0_stall", int'(BusStall), 1);
      chk("f1_c0_commit", int'(BusCommitted), 0);
      tick(); CacheBusRW = 2'b00; #3;
      chk("f1_c1_htrans", int'(HTRANS), 3);
      chk("f1_c1_bidx", int'(BeatIndex), 3);
      chk("f1_c1_bidd", int'(BeatIndexDelayed), 2);
      chk("f1_c1_cap", int'(CaptureEn), 1);
      chk("f1_c1_commit", int'(BusCommitted), 1);
      tick(); #3;
      chk("f1_c2_htrans", int'(HTRANS), 3);
      chk("f1_c2_bidx", int'(BeatIndex), 0);
      chk("f1_c2_bidd", int'(BeatIndexDelayed), 3);
      tick(); #3;
      chk("f1_c3_htrans", int'(HTRANS), 3);
      chk("f1_c3_bidx", int'(BeatIndex), 1);
      chk("f1_c3_ack", int'(CacheBusAck), 0);
      tick(); #3;
      chk("f1_c4_htrans", int'(HTRANS), 0);
      chk("f1_c4_bidd", int'(BeatIndexDelayed), 1);
      chk("f1_c4_ack", int'(CacheBusAck), 1);
      chk("f1_c4_stall", int'(BusStall), 0);
      chk("f1_c4_hburst", int'(HBURST), 0);
      tick(); #3;
      chk("f1_c5_commit", int'(BusCommitted), 0);
      chk("f1_c5_ack", int'(CacheBusAck), 0);
      tick();

      // same fetch, beat 1 stretched by 3 wait states
      CacheBusRW = 2'b10; CritBeat = 2'd2; #3;
      chk("f2_c0_bidx", int'(BeatIndex), 2);
      tick(); CacheBusRW = 2'b00;
      for (int i = 0; i < 3; i++) begin
         HREADY = 1'b0; #3;
         chk("f2_wait_bidx", int'(BeatIndex), 3);
         chk("f2_wait_bidd", int'(BeatIndexDelayed), 2);
         chk("f2_wait_cap", int'(CaptureEn), 0);
         chk("f2_wait_ack", int'(CacheBusAck), 0);
         tick();
      end
      HREADY = 1'b1; #3;
      chk("f2_c4_bidx", int'(BeatIndex), 3);
      chk("f2_c4_cap", int'(CaptureEn), 1);
      tick(); #3;
      chk("f2_c5_bidx", int'(BeatIndex), 0);
      chk("f2_c5_ack", int'(CacheBusAck), 0);
      tick(); #3;
      chk("f2_c6_ack", int'(CacheBusAck), 0);
      tick(); #3;
      chk("f2_c7_ack", int'(CacheBusAck), 1);
      chk("f2_c7_bidd", int'(BeatIndexDelayed), 1);
      tick();

      // writeback (crit 1) followed immediately by fetch (crit 3)
      CacheBusRW = 2'b01; CritBeat = 2'd1; #3;
      chk("wb_c0_htrans", int'(HTRANS), 2);
      chk("wb_c0_hwrite", int'(HWRITE), 1);
      chk("wb_c0_bidx", int'(BeatIndex), 1);
      chk("wb_c0_sel", int'(SelBusBeat), 1);
      tick(); CacheBusRW = 2'b10; CritBeat = 2'd3; #3;
      chk("wb_c1_htrans", int'(HTRANS), 3);
      chk("wb_c1_hwrite", int'(HWRITE), 1);
      chk("wb_c1_bidx", int'(BeatIndex), 2);
      chk("wb_c1_cap", int'(CaptureEn), 0);
      tick(); tick(); #3;
      chk("wb_c3_bidx", int'(BeatIndex), 0);
      tick(); #3;
      chk("wb_c4_ack", int'(CacheBusAck), 1);
      chk("wb_c4_htrans", int'(HTRANS), 2);
      chk("wb_c4_hwrite", int'(HWRITE), 0);
      chk("wb_c4_bidx", int'(BeatIndex), 3);
      chk("wb_c4_bidd", int'(BeatIndexDelayed), 0);
      chk("wb_c4_hburst", int'(HBURST), 2);
      chk("wb_c4_stall", int'(BusStall), 0);
      tick(); CacheBusRW = 2'b00; #3;
      chk("wb_c5_htrans", int'(HTRANS), 3);
      chk("wb_c5_bidx", int'(BeatIndex), 0);
      chk("wb_c5_bidd", int'(BeatIndexDelayed), 3);
      chk("wb_c5_cap", int'(CaptureEn), 1);
      chk("wb_c5_ack", int'(CacheBusAck), 0);
      tick(); tick(); tick(); #3;
      chk("wb_c8_ack", int'(CacheBusAck), 1);
      chk("wb_c8_htrans", int'(HTRANS), 0);
      tick();

      // fetch with error response on beat 1
      CacheBusRW = 2'b10; CritBeat = 2'd0; #3;
      chk("er_c0_bidx", int'(BeatIndex), 0);
      tick(); CacheBusRW = 2'b00; #3;
      chk("er_c1_cap", int'(CaptureEn), 1);
      tick(); HREADY = 1'b0; HRESP = 1'b1; #3;
      chk("er_c2_bidd", int'(BeatIndexDelayed), 1);
      chk("er_c2_cap", int'(CaptureEn), 0);
      tick(); #3;
      chk("er_c3_htrans", int'(HTRANS), 0);
      chk("er_c3_buserr", int'(BusErr), 0);
      chk("er_c3_ack", int'(CacheBusAck), 0);
      chk("er_c3_stall", int'(BusStall), 1);
      tick(); HREADY = 1'b1; #3;
      chk("er_c4_htrans", int'(HTRANS), 0);
      chk("er_c4_buserr", int'(BusErr), 1);
      chk("er_c4_ack", int'(CacheBusAck), 1);
      tick(); HRESP = 1'b0; #3;
      chk("er_c5_commit", int'(BusCommitted), 0);
      chk("er_c5_buserr", int'(BusErr), 0);
      chk("er_c5_stall", int'(BusStall), 0);
      tick();

      // uncached write, flushed on the first cycle, then held in MEM3 by Stall
      BusRW = 2'b01; Flush = 1'b1; #3;
      chk("uw_fl_htrans", int'(HTRANS), 0);
      chk("uw_fl_stall", int'(BusStall), 0);
      tick(); Flush = 1'b0; #3;
      chk("uw_c1_htrans", int'(HTRANS), 2);
      chk("uw_c1_hwrite", int'(HWRITE), 1);
      chk("uw_c1_hburst", int'(HBURST), 0);
      chk("uw_c1_stall", int'(BusStall), 1);
      tick(); Stall = 1'b1; #3;
      chk("uw_dp_commit", int'(BusCommitted), 1);
      chk("uw_dp_sel", int'(SelBusBeat), 1);
      chk("uw_dp_htrans", int'(HTRANS), 0);
      chk("uw_dp_stall", int'(BusStall), 1);
      tick(); BusRW = 2'b00;
      for (int i = 0; i < 3; i++) begin
         #3;
         chk("uw_m3_commit", int'(BusCommitted), 1);
         chk("uw_m3_stall", int'(BusStall), 0);
         chk("uw_m3_buserr", int'(BusErr), 0);
         tick();
      end
      Stall = 1'b0; #3;
      chk("uw_m3_exit_commit", int'(BusCommitted), 1);
      tick(); #3;
      chk("uw_idle_commit", int'(BusCommitted), 0);
      tick();

      // uncached read with error: BusErr carried through MEM3
      BusRW = 2'b10; #3;
      chk("ur_c0_htrans", int'(HTRANS), 2);
      chk("ur_c0_hwrite", int'(HWRITE), 0);
      tick(); BusRW = 2'b00; HREADY = 1'b0; HRESP = 1'b1; #3;
      chk("ur_c1_cap", int'(CaptureEn), 0);
      tick(); HREADY = 1'b1; #3;
      chk("ur_c2_buserr", int'(BusErr), 1);
      chk("ur_c2_ack", int'(CacheBusAck), 0);
      tick(); HRESP = 1'b0; Stall = 1'b1; #3;
      chk("ur_m3_buserr", int'(BusErr), 1);
      chk("ur_m3_commit", int'(BusCommitted), 1);
      tick(); Stall = 1'b0; #3;
      chk("ur_m3b_buserr", int'(BusErr), 1);
      tick(); #3;
      chk("ur_idle_buserr", int'(BusErr), 0);
      chk("ur_idle_commit", int'(BusCommitted), 0);
      tick();

      // asynchronous reset during beat 2 of a fetch
      CacheBusRW = 2'b10; CritBeat = 2'd1; #3;
      chk("ar_c0_bidx", int'(BeatIndex), 1);
      tick(); CacheBusRW = 2'b00; #3;
      chk("ar_c1_bidx", int'(BeatIndex), 2);
      tick(); #3;
      chk("ar_c2_bidx", int'(BeatIndex), 3);
      chk("ar_c2_htrans", int'(HTRANS), 3);
      #2; HRESET = 1'b1; #1;
      chk("ar_htrans", int'(HTRANS), 0);
      chk("ar_bidx", int'(BeatIndex), 0);
      chk("ar_bidd", int'(BeatIndexDelayed), 0);
      chk("ar_ack", int'(CacheBusAck), 0);
      chk("ar_commit", int'(BusCommitted), 0);
      chk("ar_stall", int'(BusStall), 0);
      tick(); HRESET = 1'b0; #3;
      chk("ar_post_htrans", int'(HTRANS), 0);
      chk("ar_post_commit", int'(BusCommitted), 0);
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
      $finish;
   end

endmodule
